// File: rtl/bcd_display_mux.sv
// Two-digit multiplexed 7-segment driver with per-frame snapshot and inter-digit blanking.
// Define BCD_DISP_LZB_EN to blank a leading zero in the tens slot.
module bcd_display_mux #(
  parameter int unsigned REFRESH_DIV    = 1000,
  parameter int unsigned GAP_CYC        = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       _rst,
  input  logic [7:0] bcd_in,
  output logic [6:0] seg,
  output logic [1:0] dig,
  output logic       frame_start,
  output logic       err
);

  localparam int unsigned MaxDur = (REFRESH_DIV > GAP_CYC) ? REFRESH_DIV : GAP_CYC;
  localparam int unsigned CntW   = $clog2(MaxDur + 1);

  localparam logic [CntW-1:0] RefLoad = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] GapLoad = CntW'(GAP_CYC - 1);

  // Polarity masks; XOR with the logical (1 = lit) pattern gives the pin level.
  localparam logic [6:0] SegInv = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0] DigInv = DIG_ACTIVE_LOW ? 2'b11 : 2'b00;

  typedef enum logic [1:0] {
    StUnits,
    StGapU,
    StTens,
    StGapT
  } state_e;

  state_e          state_q;
  state_e          next_state;
  logic [CntW-1:0] cnt_q;
  logic [7:0]      snap_q;
  logic [6:0]      seg_q;
  logic [1:0]      dig_q;
  logic            frame_start_q;
  logic            err_q;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    pat = 7'h40;
    unique case (nib)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = 7'h40;
    endcase
    return pat;
  endfunction

  always_comb begin
    next_state = StUnits;
    unique case (state_q)
      StUnits: next_state = StGapU;
      StGapU:  next_state = StTens;
      StTens:  next_state = StGapT;
      StGapT:  next_state = StUnits;
      default: next_state = StUnits;
    endcase
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state_q       <= StGapT;
      cnt_q         <= GapLoad;
      snap_q        <= 8'h00;
      seg_q         <= SegInv;
      dig_q         <= DigInv;
      frame_start_q <= 1'b0;
      err_q         <= 1'b0;
    end else if (cnt_q == '0) begin
      state_q <= next_state;
      unique case (next_state)
        StUnits: begin
          // Snapshot taken here; decode straight from bcd_in since snap_q updates on this edge.
          cnt_q         <= RefLoad;
          snap_q        <= bcd_in;
          err_q         <= (bcd_in[7:4] > 4'd9) | (bcd_in[3:0] > 4'd9);
          frame_start_q <= 1'b1;
          seg_q         <= seg_decode(bcd_in[3:0]) ^ SegInv;
          dig_q         <= 2'b01 ^ DigInv;
        end
        StTens: begin
          cnt_q         <= RefLoad;
          frame_start_q <= 1'b0;
`ifdef BCD_DISP_LZB_EN
          if (snap_q[7:4] == 4'd0) begin
            seg_q <= SegInv;
            dig_q <= DigInv;
          end else begin
            seg_q <= seg_decode(snap_q[7:4]) ^ SegInv;
            dig_q <= 2'b10 ^ DigInv;
          end
`else
          seg_q <= seg_decode(snap_q[7:4]) ^ SegInv;
          dig_q <= 2'b10 ^ DigInv;
`endif
        end
        default: begin
          cnt_q         <= GapLoad;
          frame_start_q <= 1'b0;
          seg_q         <= SegInv;
          dig_q         <= DigInv;
        end
      endcase
    end else begin
      cnt_q         <= cnt_q - 1'b1;
      frame_start_q <= 1'b0;
    end
  end

  assign seg         = seg_q;
  assign dig         = dig_q;
  assign frame_start = frame_start_q;
  assign err         = err_q;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Directed bench for bcd_display_mux with REFRESH_DIV=4, GAP_CYC=1, active-low outputs.
module tb_bcd_display_mux;

  localparam logic [6:0] SI = 7'h7F;
  localparam logic [1:0] DI = 2'b11;

  logic       clk;
  logic       _rst;
  logic [7:0] bcd_in;
  logic [6:0] seg;
  logic [1:0] dig;
  logic       frame_start;
  logic       err;

  int total = 0;
  int bad   = 0;

  bcd_display_mux #(
    .REFRESH_DIV   (4),
    .GAP_CYC       (1),
    .SEG_ACTIVE_LOW(1'b1),
    .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk        (clk),
    ._rst       (_rst),
    .bcd_in     (bcd_in),
    .seg        (seg),
    .dig        (dig),
    .frame_start(frame_start),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts just before a capture edge; ends in the last GAP_T cycle.
  task automatic run_frame(input logic [6:0] u_l, input logic [6:0] t_l, input logic [1:0] t_dig_l,
                           input logic exp_err, input logic [7:0] nxt);
    tick();
    check("fs_entry", {7'd0, frame_start}, 8'd1);
    check("seg_units", {1'b0, seg}, {1'b0, u_l ^ SI});
    check("dig_units", {6'd0, dig}, {6'd0, 2'b01 ^ DI});
    check("err_entry", {7'd0, err}, {7'd0, exp_err});
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fs_units_low", {7'd0, frame_start}, 8'd0);
      check("seg_units_hold", {1'b0, seg}, {1'b0, u_l ^ SI});
      check("dig_units_hold", {6'd0, dig}, {6'd0, 2'b01 ^ DI});
    end
    tick();
    check("seg_gap_u", {1'b0, seg}, {1'b0, SI});
    check("dig_gap_u", {6'd0, dig}, {6'd0, DI});
    tick();
    check("seg_tens", {1'b0, seg}, {1'b0, t_l ^ SI});
    check("dig_tens", {6'd0, dig}, {6'd0, t_dig_l ^ DI});
    bcd_in = nxt;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("seg_tens_hold", {1'b0, seg}, {1'b0, t_l ^ SI});
      check("dig_tens_hold", {6'd0, dig}, {6'd0, t_dig_l ^ DI});
    end
    tick();
    check("seg_gap_t", {1'b0, seg}, {1'b0, SI});
    check("dig_gap_t", {6'd0, dig}, {6'd0, DI});
    check("fs_gap_t", {7'd0, frame_start}, 8'd0);
    check("err_held", {7'd0, err}, {7'd0, exp_err});
  endtask

  initial begin
    int last_fs;
    int fs_count;
    logic [1:0] dig_l;

    _rst   = 1'b0;
    bcd_in = 8'h42;
    #7;
    check("rst_seg", {1'b0, seg}, 8'h7F);
    check("rst_dig", {6'd0, dig}, 8'h03);
    check("rst_fs", {7'd0, frame_start}, 8'd0);
    check("rst_err", {7'd0, err}, 8'd0);
    @(negedge clk);
    _rst = 1'b1;
    #1;
    check("pre_frame_seg", {1'b0, seg}, 8'h7F);
    check("pre_frame_dig", {6'd0, dig}, 8'h03);

    run_frame(7'h5B, 7'h66, 2'b10, 1'b0, 8'h17);  // 42, change to 17 mid-TENS
    run_frame(7'h07, 7'h06, 2'b10, 1'b0, 8'hA5);  // 17
    run_frame(7'h6D, 7'h40, 2'b10, 1'b1, 8'h55);  // A5: dash tens, err
    run_frame(7'h6D, 7'h6D, 2'b10, 1'b0, 8'h07);  // 55: err cleared
`ifdef BCD_DISP_LZB_EN
    run_frame(7'h3F, 7'h00, 2'b00, 1'b0, 8'hA5);  // 07 with leading zero blanked
`else
    run_frame(7'h07, 7'h3F, 2'b10, 1'b0, 8'hA5);  // 07, tens shows 0
`endif

    // Capture A5 then reset asynchronously in UNITS, away from any edge.
    tick();
    check("err_before_rst", {7'd0, err}, 8'd1);
    check("dig_before_rst", {6'd0, dig}, 8'h02);
    #2;
    _rst = 1'b0;
    #1;
    check("arst_seg", {1'b0, seg}, 8'h7F);
    check("arst_dig", {6'd0, dig}, 8'h03);
    check("arst_err", {7'd0, err}, 8'd0);
    check("arst_fs", {7'd0, frame_start}, 8'd0);
    bcd_in = 8'h42;
    @(negedge clk);
    _rst = 1'b1;
    run_frame(7'h5B, 7'h66, 2'b10, 1'b0, 8'h42);

    // 20 frames: digit exclusivity and frame_start period every cycle.
    last_fs  = -1;
    fs_count = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      dig_l = dig ^ DI;
      check("dig_onehot", {7'd0, dig_l != 2'b11}, 8'd1);
      if (frame_start) begin
        if (last_fs >= 0) check("fs_period", 8'(c - last_fs), 8'd10);
        else check("fs_first", 8'(c), 8'd0);
        last_fs = c;
        fs_count++;
      end
    end
    check("fs_count", 8'(fs_count), 8'd20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
